// File: rtl/demux32_pkg.sv
// demux32_pkg: shared FSM states, slot geometry constants and slot decode helper for demux32_tdm
package demux32_pkg;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

    localparam int NUM_SLOTS = 32;
    localparam int LANE_W    = 8;
    localparam int SLOT_W    = 5;
    localparam int LANE_MSB  = 4;
    localparam int LANE_LSB  = 3;
    localparam int BIT_MSB   = 2;

    // Flat shadow index of a slot: lane field selects the byte, bit field the bit inside it
    function automatic logic [SLOT_W-1:0] slot_index(input logic [SLOT_W-1:0] s);
        return {s[LANE_MSB:LANE_LSB], s[BIT_MSB:0]};
    endfunction

endpackage

// File: rtl/demux32_slot_ctr.sv
// demux32_slot_ctr: 5-bit scan slot counter with enable, synchronous clear and terminal-count flag
module demux32_slot_ctr
    import demux32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic [SLOT_W-1:0] cnt,
    output logic              tc
);

    logic [SLOT_W-1:0] cnt_q, cnt_d;

    // Clear wins over count; counting past the last slot wraps to zero
    always_comb begin
        cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = cnt_q == SLOT_W'(NUM_SLOTS - 1);

endmodule

// File: rtl/demux32_tdm.sv
// demux32_tdm: rebuilds four 8-bit lanes from a 1-bit TDM stream; optional scan parity via DEMUX32_PARITY_EN
module demux32_tdm
    import demux32_pkg::*;
#(
    parameter logic [NUM_SLOTS-1:0] RST_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SLOT_W-1:0] sel,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              commit,
    output logic [LANE_W-1:0] a,
    output logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] c,
    output logic [LANE_W-1:0] d,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [SLOT_W-1:0] slot,
    output logic              parity_err
);

`ifdef DEMUX32_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [NUM_SLOTS-1:0]   shadow_q, shadow_d;
    logic [NUM_SLOTS-1:0]   out_q, out_d;
    logic                   fv_q, fv_d;
    logic                   pw_q, pw_d;
    logic                   pe_q, pe_d;
    logic                   scan, acc, pub, hs, tc, ctr_en, ctr_clr, last_data;
    logic [SLOT_W-1:0]      idx;

    demux32_slot_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctr_en),
        .clr   (ctr_clr),
        .cnt   (slot),
        .tc    (tc)
    );

    assign din_ready = rst_n && state_q != HOLD;

    // Acceptance, shadow write-through, publish decision and FSM next state
    always_comb begin
        scan      = state_q == IDLE ? mode : mode_q;
        acc       = din_valid && din_ready;
        idx       = slot_index(scan ? slot : sel);
        last_data = acc && scan && tc && !pw_q;
        shadow_d  = shadow_q;
        if (acc && !pw_q) shadow_d[idx] = din;
        pub       = state_q == FILL && (scan ? (PAR ? acc && pw_q : last_data) : commit);
        hs        = state_q == HOLD && fv_q && frame_ready;
        ctr_en    = acc && scan && !(PAR && tc);
        ctr_clr   = PAR && pub && scan;
        pw_d      = PAR && (pw_q ? !acc : last_data);
        pe_d      = PAR && pub && scan ? ^shadow_q ^ din : pe_q;
        out_d     = pub ? shadow_d : out_q;
        fv_d      = pub || (fv_q && !hs);
        mode_d    = state_q == IDLE && acc ? mode : mode_q;
        state_d   = state_q == IDLE ? (acc ? FILL : IDLE) :
                    state_q == FILL ? (pub ? HOLD : FILL) :
                    (hs ? IDLE : HOLD);
    end

    // State, shadow and published-frame registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            shadow_q <= RST_VAL;
            out_q    <= RST_VAL;
            fv_q     <= 1'b0;
            pw_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            fv_q     <= fv_d;
            pw_q     <= pw_d;
            pe_q     <= pe_d;
        end
    end

    assign a           = out_q[0*LANE_W +: LANE_W];
    assign b           = out_q[1*LANE_W +: LANE_W];
    assign c           = out_q[2*LANE_W +: LANE_W];
    assign d           = out_q[3*LANE_W +: LANE_W];
    assign frame_valid = fv_q;
    assign parity_err  = pe_q;

endmodule

// File: doc/demux32_tdm.md
Name: demux32_tdm

Overview:
- Receive-side counterpart of the 32:1 bit multiplexer: rebuilds four 8-bit lanes (a, b, c, d) from a 1-bit serial stream.
- Slots are numbered 0..31: slot[4:3] selects the lane (00=a, 01=b, 10=c, 11=d); slot[2:0] selects the bit index within that lane.
- Captured bits go into a shadow frame. The shadow is published to the output registers through a valid/ready frame handshake.

Parameters:
- RST_VAL, 32'h0000_0000, reset value of the shadow frame and of the {d,c,b,a} output registers.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = addressed (slot taken from sel); 1 = scan (slot taken from the internal counter).
- sel  in  5  slot address; used only when mode=0.
- din  in  1  serial data bit.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  block accepts din this cycle.
- commit  in  1  addressed mode only: publish the shadow frame (one-cycle pulse).
- a, b, c, d  out  8 each  published lanes; registered.
- frame_valid  out  1  a new frame is published and not yet acknowledged.
- frame_ready  in  1  consumer acknowledges the published frame.
- slot  out  5  current scan counter value.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Bit acceptance: a bit is accepted when din_valid & din_ready. The accepted bit is written to shadow[lane][bit] in the same edge; all other shadow bits hold.
- Reset (asynchronous, any time, including mid-frame):
  - shadow = RST_VAL; {d,c,b,a} = RST_VAL.
  - slot = 0, frame_valid = 0, parity_err = 0, FSM = IDLE.
  - din_ready goes to 1 in the first cycle after rst_n rises.
- FSM states: IDLE, FILL, HOLD.
  - IDLE: din_ready=1. First accepted bit: go to FILL; in scan mode slot increments to 1.
  - FILL, scan mode: each accepted bit writes slot, then slot increments. The bit accepted at slot 31 completes the frame: shadow is copied to the outputs on that same edge (write-through, so bit 31 is included), frame_valid is set next cycle, slot wraps to 0, and the FSM goes to HOLD.
  - FILL, addressed mode: bits are written at sel and may arrive in any order, with repeats allowed (last write wins). commit=1 publishes the shadow; if a bit is accepted in the same cycle, that bit is included. FSM goes to HOLD.
  - HOLD: din_ready=0 and no shadow writes. When frame_valid & frame_ready, frame_valid clears next cycle, the FSM returns to IDLE, and din_ready=1 on that cycle.
- Latency: the published lanes are visible, with frame_valid=1, one cycle after the completing bit or commit.
- The outputs change only on publish or reset. The shadow is not cleared between frames; the previous frame's values persist in slots that are not rewritten.
- Mode changes:
  - mode may change only in IDLE. A change in FILL or HOLD is ignored until the next return to IDLE; the mode is latched on the IDLE-to-FILL transition.
  - commit while mode=1, or while in IDLE or HOLD, is ignored.
- din_valid while din_ready=0: ignored; the bit is dropped and nothing is stored.

Optional Feature:
- Macro: DEMUX32_PARITY_EN (scan mode only).
- Defined:
  - A 33rd bit (even parity over the 32 data bits) follows slot 31. slot holds at 31 while it is awaited, and din_ready stays 1.
  - Publish happens on acceptance of the parity bit.
  - parity_err is registered with the publish: 1 if the XOR of the 32 data bits and the parity bit is 1. It holds until the next publish or reset.
- Not defined: no parity slot; parity_err is tied to 0.

Decomposition:
- Package demux32_pkg:
  - FSM state enum {IDLE, FILL, HOLD}.
  - Constants: NUM_SLOTS=32, LANE_W=8, and slot field positions LANE_MSB=4, LANE_LSB=3, BIT_MSB=2.
- One sub-module, demux32_slot_ctr: the 5-bit scan counter with enable, synchronous clear, and wrap/terminal-count flag.

Test Plan:
- Reset: hold rst_n=0 with RST_VAL=0 → a=b=c=d=8'h00, frame_valid=0, slot=0, din_ready=0 during reset.
- Scan mode: stream 32 bits forming {d,c,b,a}=32'hB0_86_90_80, frame_ready=0 → frame_valid rises one cycle after slot-31 acceptance; a=8'h80, b=8'h90, c=8'h86, d=8'hB0; din_ready=0 until frame_ready pulses.
- Addressed mode: write sel=5'd31 din=1, then sel=5'd0 din=1, then commit → d[7]=1, a[0]=1, all other bits retain the previous frame values.
- Backpressure: during HOLD drive din_valid=1 with din=1 for 10 cycles → shadow unchanged; after frame_ready, next frame starts at slot 0.
- Reset mid-frame: assert rst_n=0 after 17 accepted scan bits → slot=0, outputs=RST_VAL; a fresh 32-bit frame then publishes correctly.
- DEMUX32_PARITY_EN: send 32'h0000_0001 with parity bit 0 → parity_err=1; with parity bit 1 → parity_err=0.
